// File: rtl/core_pkg.sv
// core_pkg: shared core data width, byte-lane geometry and memory-access
// encodings, plus the alignment/legality helpers used by the load/store unit.
package core_pkg;

    localparam int Xlen = 32;
    localparam int Nb   = Xlen / 8;
    localparam int Ob   = $clog2(Nb);

    typedef enum logic [1:0] {
        SzByte   = 2'd0,
        SzHalf   = 2'd1,
        SzWord   = 2'd2,
        SzDouble = 2'd3
    } mem_size_e;

    // Byte-lane mask of an access of the given size, anchored at lane 0.
    function automatic logic [Nb-1:0] size_mask(input mem_size_e size);
        logic [Nb-1:0] mask;
        mask = '0;
        for (int i = 0; i < Nb; i++) begin
            mask[i] = (i < (32'sd1 << size));
        end
        return mask;
    endfunction

    // An access is misaligned when its low address bits are not a multiple of its size.
    function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] low_addr);
        logic mis;
        case (size)
            SzByte:   mis = 1'b0;
            SzHalf:   mis = low_addr[0];
            SzWord:   mis = |low_addr[1:0];
            SzDouble: mis = |low_addr[2:0];
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Size/signedness combinations the core cannot execute.
    function automatic logic is_illegal(input mem_size_e size, input logic is_unsigned,
                                        input logic is_store);
        logic ill;
        ill = 1'b0;
        if (is_store && is_unsigned) begin
            ill = 1'b1;
        end
        if ((size == SzDouble) && ((Xlen == 32'sd32) || is_unsigned)) begin
            ill = 1'b1;
        end
        if ((size == SzWord) && is_unsigned && (Xlen == 32'sd32)) begin
            ill = 1'b1;
        end
        return ill;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering. Store side builds the byte-lane mask
// and replicated write data; load side shifts the returned word down to the
// accessed bytes and sign/zero-extends them.
module lsu_align
    import core_pkg::*;
(
    input  mem_size_e         st_size_i,
    input  logic [Ob-1:0]     st_offset_i,
    input  logic [Xlen-1:0]   st_wdata_i,
    output logic [Nb-1:0]     st_wmask_o,
    output logic [Xlen-1:0]   st_wdata_o,
    input  mem_size_e         ld_size_i,
    input  logic              ld_unsigned_i,
    input  logic [Ob-1:0]     ld_offset_i,
    input  logic [Xlen-1:0]   ld_rdata_i,
    output logic [Xlen-1:0]   ld_rdata_o
);

    logic [Xlen-1:0] shifted_s;
    logic [6:0]      width_s;
    logic            sign_s;

    assign st_wmask_o = size_mask(st_size_i) << st_offset_i;
    assign shifted_s  = ld_rdata_i >> {ld_offset_i, 3'b000};

    // Replicate store data so every aligned offset finds its bytes on its own lanes.
    always_comb begin
        st_wdata_o = st_wdata_i;
        case (st_size_i)
            SzByte:   st_wdata_o = {Nb{st_wdata_i[7:0]}};
            SzHalf:   st_wdata_o = {(Nb / 2){st_wdata_i[15:0]}};
            SzWord:   st_wdata_o = {(Nb / 4){st_wdata_i[31:0]}};
            SzDouble: st_wdata_o = st_wdata_i;
            default:  st_wdata_o = st_wdata_i;
        endcase
    end

    // Pick the loaded field width and its sign bit.
    always_comb begin
        width_s = 7'd64;
        sign_s  = shifted_s[Xlen-1];
        case (ld_size_i)
            SzByte: begin
                width_s = 7'd8;
                sign_s  = shifted_s[7];
            end
            SzHalf: begin
                width_s = 7'd16;
                sign_s  = shifted_s[15];
            end
            SzWord: begin
                width_s = 7'd32;
                sign_s  = shifted_s[31];
            end
            SzDouble: begin
                width_s = 7'd64;
                sign_s  = shifted_s[Xlen-1];
            end
            default: begin
                width_s = 7'd64;
                sign_s  = shifted_s[Xlen-1];
            end
        endcase
    end

    // Keep the field bits and fill the rest with the sign or with zero.
    always_comb begin
        ld_rdata_o = '0;
        for (int i = 0; i < Xlen; i++) begin
            if (i < int'(width_s)) begin
                ld_rdata_o[i] = shifted_s[i];
            end else begin
                ld_rdata_o[i] = sign_s & ~ld_unsigned_i;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: executes one load or store at a time against a valid/ready
// data-memory port and stalls the core (busy_o) until completion. Alignment and
// legality faults complete immediately without touching memory.
module load_store_unit
    import core_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [Xlen-1:0]   addr_i,
    input  logic [Xlen-1:0]   wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [Xlen-1:0]   rdata_o,
    output logic              misaligned_o,
    output logic              illegal_o,
    output logic              dmem_valid_o,
    input  logic              dmem_ready_i,
    output logic              dmem_we_o,
    output logic [Xlen-1:0]   dmem_addr_o,
    output logic [Nb-1:0]     dmem_wmask_o,
    output logic [Xlen-1:0]   dmem_wdata_o,
    input  logic              dmem_rvalid_i,
    input  logic [Xlen-1:0]   dmem_rdata_i
);

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Req  = 2'd1,
        Wait = 2'd2,
        Resp = 2'd3
    } lsu_state_e;

    lsu_state_e      state_r;
    mem_size_e       size_r;
    logic            unsigned_r;
    logic [Ob-1:0]   offset_r;
    logic            we_r;
    logic            busy_r;
    logic            done_r;
    logic [Xlen-1:0] rdata_r;
    logic            misaligned_r;
    logic            illegal_r;
    logic            dmem_valid_r;
    logic            dmem_we_r;
    logic [Xlen-1:0] dmem_addr_r;
    logic [Nb-1:0]   dmem_wmask_r;
    logic [Xlen-1:0] dmem_wdata_r;

    mem_size_e       size_s;
    logic            unsigned_s;
    logic            is_store_s;
    logic            accept_s;
    logic            illegal_s;
    logic            misaligned_s;
    logic            fault_s;
    logic [Nb-1:0]   st_wmask_s;
    logic [Xlen-1:0] st_wdata_s;
    logic [Xlen-1:0] ld_rdata_s;

    lsu_align u_align (
        .st_size_i     (size_s),
        .st_offset_i   (addr_i[Ob-1:0]),
        .st_wdata_i    (wdata_i),
        .st_wmask_o    (st_wmask_s),
        .st_wdata_o    (st_wdata_s),
        .ld_size_i     (size_r),
        .ld_unsigned_i (unsigned_r),
        .ld_offset_i   (offset_r),
        .ld_rdata_i    (dmem_rdata_i),
        .ld_rdata_o    (ld_rdata_s)
    );

    // Decode the presented operation and its fault status ahead of acceptance.
    always_comb begin
        size_s       = mem_size_e'(funct3_i[1:0]);
        unsigned_s   = funct3_i[2];
        is_store_s   = mem_write_i;
        accept_s     = valid_i & (mem_read_i | mem_write_i) & ~done_r;
        illegal_s    = is_illegal(size_s, unsigned_s, is_store_s);
        misaligned_s = is_misaligned(size_s, addr_i[2:0]);
        fault_s      = illegal_s | misaligned_s;
    end

    // Access sequencer: accept, request, await load data, pulse completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= Idle;
            size_r       <= SzByte;
            unsigned_r   <= 1'b0;
            offset_r     <= '0;
            we_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rdata_r      <= '0;
            misaligned_r <= 1'b0;
            illegal_r    <= 1'b0;
            dmem_valid_r <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= '0;
            dmem_wmask_r <= '0;
            dmem_wdata_r <= '0;
        end else begin
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            illegal_r    <= 1'b0;
            case (state_r)
                Idle: begin
                    if (accept_s) begin
                        busy_r     <= 1'b1;
                        we_r       <= is_store_s;
                        size_r     <= size_s;
                        unsigned_r <= unsigned_s;
                        offset_r   <= addr_i[Ob-1:0];
                        if (fault_s) begin
                            // Faults finish at once; illegal takes precedence over misaligned.
                            state_r      <= Resp;
                            done_r       <= 1'b1;
                            illegal_r    <= illegal_s;
                            misaligned_r <= misaligned_s & ~illegal_s;
                            rdata_r      <= '0;
                        end else begin
                            state_r      <= Req;
                            dmem_valid_r <= 1'b1;
                            dmem_we_r    <= is_store_s;
                            dmem_addr_r  <= {addr_i[Xlen-1:Ob], {Ob{1'b0}}};
                            dmem_wmask_r <= is_store_s ? st_wmask_s : {Nb{1'b0}};
                            dmem_wdata_r <= is_store_s ? st_wdata_s : {Xlen{1'b0}};
                        end
                    end else begin
                        state_r <= Idle;
                    end
                end
                Req: begin
                    if (dmem_ready_i) begin
                        dmem_valid_r <= 1'b0;
                        if (we_r) begin
                            state_r <= Resp;
                            done_r  <= 1'b1;
                            rdata_r <= '0;
                        end else begin
                            state_r <= Wait;
                        end
                    end else begin
                        state_r <= Req;
                    end
                end
                Wait: begin
                    if (dmem_rvalid_i) begin
                        state_r <= Resp;
                        done_r  <= 1'b1;
                        rdata_r <= ld_rdata_s;
                    end else begin
                        state_r <= Wait;
                    end
                end
                Resp: begin
                    state_r <= Idle;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r      <= Idle;
                    busy_r       <= 1'b0;
                    dmem_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign rdata_o      = rdata_r;
    assign misaligned_o = misaligned_r;
    assign illegal_o    = illegal_r;
    assign dmem_valid_o = dmem_valid_r;
    assign dmem_we_o    = dmem_we_r;
    assign dmem_addr_o  = dmem_addr_r;
    assign dmem_wmask_o = dmem_wmask_r;
    assign dmem_wdata_o = dmem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: drives directed and random loads/stores, plays the data
// memory, and checks every cycle against a byte-array memory model and a
// transaction timeline derived from the access rules.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni, valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        busy_o, done_o, misaligned_o, illegal_o;
    logic [31:0] rdata_o;
    logic        dmem_valid_o, dmem_ready_i, dmem_we_o, dmem_rvalid_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_wmask_o;

    load_store_unit dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .rdata_o       (rdata_o),
        .misaligned_o  (misaligned_o),
        .illegal_o     (illegal_o),
        .dmem_valid_o  (dmem_valid_o),
        .dmem_ready_i  (dmem_ready_i),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wmask_o  (dmem_wmask_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  mem [0:1023];
    logic        chk_en;
    logic        e_busy, e_done, e_mis, e_ill, e_dvalid, e_we, e_wchk;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_mask;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_mask;
    logic        seen_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] a, input int n, input logic uns);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mem[a[9:0] + 10'(k)];
        if (!uns && v[8*n-1]) begin
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Per-cycle comparison of every DUT output against the expected timeline.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy_o), 32'(e_busy));
            chk("done", 32'(done_o), 32'(e_done));
            chk("rdata", rdata_o, e_rdata);
            chk("misaligned", 32'(misaligned_o), 32'(e_mis));
            chk("illegal", 32'(illegal_o), 32'(e_ill));
            chk("dmem_valid", 32'(dmem_valid_o), 32'(e_dvalid));
            if (e_dvalid) begin
                chk("dmem_we", 32'(dmem_we_o), 32'(e_we));
                chk("dmem_addr", dmem_addr_o, e_addr);
                chk("dmem_wmask", 32'(dmem_wmask_o), 32'(e_mask));
                if (e_wchk) chk("dmem_wdata", dmem_wdata_o, e_wdata);
            end
        end
    end

    task automatic set_idle_exp();
        e_busy = 1'b0; e_done = 1'b0; e_mis = 1'b0; e_ill = 1'b0; e_dvalid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        set_idle_exp();
        valid_i = 1'($urandom_range(0, 1));
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        dmem_ready_i = 1'($urandom_range(0, 1));
        dmem_rvalid_i = 1'($urandom_range(0, 1));
        dmem_rdata_i = $urandom;
    endtask

    // One operation: returns at #1 into its done cycle (or the cycle after a no-op).
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int rlat, input int vlat, input logic hold);
        int n;
        logic uns, we, ill, mis;
        logic [31:0] lanes;
        logic [3:0] mask;
        n   = 1 << f3[1:0];
        uns = f3[2];
        we  = wr;
        ill = (f3[1:0] == 2'd3) || (we && uns) || ((f3[1:0] == 2'd2) && uns);
        mis = (int'(a[2:0]) % n) != 0;
        for (int i = 0; i < 4; i++) lanes[8*i +: 8] = wd[8*(i % n) +: 8];
        for (int i = 0; i < 4; i++) mask[i] = (i >= int'(a[1:0])) && (i < int'(a[1:0]) + n);

        @(posedge clk); #1;
        set_idle_exp();
        valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
        addr_i = a; wdata_i = wd;
        dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
        @(posedge clk); #1;
        if (!rd && !wr) begin
            valid_i = 1'b0;
        end else if (ill || mis) begin
            e_busy = 1'b1; e_done = 1'b1; e_ill = ill; e_mis = mis && !ill; e_rdata = '0;
            valid_i = hold;
        end else begin
            e_busy = 1'b1; e_dvalid = 1'b1; e_we = we; e_addr = {a[31:2], 2'b00};
            e_mask = we ? mask : 4'h0; e_wdata = lanes; e_wchk = we;
            for (int k = 0; k <= rlat; k++) begin
                dmem_ready_i = (k == rlat);
                if (k == 0) begin
                    seen_addr = dmem_addr_o; seen_mask = dmem_wmask_o;
                    seen_wdata = dmem_wdata_o; seen_we = dmem_we_o;
                end
                @(posedge clk); #1;
            end
            dmem_ready_i = 1'b0; e_dvalid = 1'b0;
            if (we) begin
                for (int k = 0; k < n; k++) mem[a[9:0] + 10'(k)] = wd[8*k +: 8];
                e_done = 1'b1; e_rdata = '0; valid_i = hold;
            end else begin
                for (int j = 0; j < vlat; j++) begin
                    dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
                    @(posedge clk); #1;
                end
                dmem_rvalid_i = 1'b1; dmem_rdata_i = mem_word(a);
                @(posedge clk); #1;
                dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
                e_done = 1'b1; e_rdata = load_value(a, n, uns); valid_i = hold;
            end
        end
    endtask

    initial begin
        int sel, n;
        logic rd, wr;
        logic [2:0] f3;
        logic [31:0] a;

        rst_ni = 1'b0; chk_en = 1'b0;
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'd0;
        addr_i = '0; wdata_i = '0; dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        set_idle_exp(); e_we = 1'b0; e_wchk = 1'b0; e_rdata = '0;
        e_addr = '0; e_wdata = '0; e_mask = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_flags", {30'd0, misaligned_o, illegal_o}, 32'd0);
        chk("rst_dmem_valid", 32'(dmem_valid_o), 32'd0);
        chk("rst_dmem_fields", dmem_addr_o | dmem_wdata_o | {28'd0, dmem_wmask_o} | 32'(dmem_we_o), 32'd0);
        rst_ni = 1'b1;
        chk_en = 1'b1;

        mem[10'h100] = 8'h34; mem[10'h101] = 8'h12; mem[10'h102] = 8'hFF; mem[10'h103] = 8'h80;
        do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 1'b0);
        chk("lb_rdata", rdata_o, 32'hFFFF_FF80);
        chk("lb_done", 32'(done_o), 32'd1);
        do_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1, 0, 1'b1);
        chk("lhu_rdata", rdata_o, 32'h0000_80FF);
        do_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 2, 1'b0);
        chk("lh_rdata", rdata_o, 32'hFFFF_80FF);

        do_op(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 3, 0, 1'b0);
        chk("sb_addr", seen_addr, 32'h0000_0100);
        chk("sb_wmask", 32'(seen_mask), 32'h0000_0002);
        chk("sb_wdata", seen_wdata, 32'hABAB_ABAB);
        chk("sb_we", 32'(seen_we), 32'd1);
        chk("sb_done", 32'(done_o), 32'd1);

        do_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 1'b0);
        chk("lw_mis_flag", 32'(misaligned_o), 32'd1);
        chk("lw_mis_ill", 32'(illegal_o), 32'd0);
        do_op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 1'b0);
        chk("ld_ill_flag", 32'(illegal_o), 32'd1);
        chk("ld_ill_mis", 32'(misaligned_o), 32'd0);

        do_op(1'b0, 1'b1, 3'b010, 32'h200, 32'h1234_5678, 0, 0, 1'b1);
        do_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 0, 1, 1'b0);
        chk("b2b_lw_rdata", rdata_o, 32'h1234_5678);

        // Reset asserted while a load waits for its data.
        idle_cycle();
        @(posedge clk); #1;
        chk_en = 1'b0;
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010;
        addr_i = 32'h300; dmem_ready_i = 1'b1; dmem_rvalid_i = 1'b0;
        @(posedge clk); #1;
        chk("rstw_req_valid", 32'(dmem_valid_o), 32'd1);
        @(posedge clk); #1;
        dmem_ready_i = 1'b0;
        chk("rstw_wait_busy", 32'(busy_o), 32'd1);
        chk("rstw_wait_valid", 32'(dmem_valid_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        chk("rstw_busy", 32'(busy_o), 32'd0);
        chk("rstw_done", 32'(done_o), 32'd0);
        chk("rstw_rdata", rdata_o, 32'd0);
        chk("rstw_dmem_valid", 32'(dmem_valid_o), 32'd0);
        valid_i = 1'b0; mem_read_i = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        chk("rstw_late_done", 32'(done_o), 32'd0);
        chk("rstw_late_rdata", rdata_o, 32'd0);
        chk("rstw_late_busy", 32'(busy_o), 32'd0);
        set_idle_exp(); e_rdata = '0;
        chk_en = 1'b1;

        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
            end else begin
                sel = $urandom_range(0, 9);
                rd = (sel == 1) || ((sel >= 2) && (sel <= 5));
                wr = (sel == 1) || (sel >= 6);
                f3 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) f3[1:0] = 2'($urandom_range(0, 2));
                if (wr && ($urandom_range(0, 3) != 0)) f3[2] = 1'b0;
                n = 1 << f3[1:0];
                a = 32'($urandom_range(0, 1023));
                if ($urandom_range(0, 2) != 0) a = a & ~32'(n - 1);
                do_op(rd, wr, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
            end
        end
        idle_cycle();
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
